// File: rtl/dir_hist_sched.sv
// Direction-histogram sequencer: walks the 16x16 window through the direction ROM,
// accumulates magnitudes into 32 bins, then streams the bins out. Optional macro: DIR_HIST_SAT_EN.
module dir_hist_sched #(
    parameter int MAG_W = 8,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [7:0]       rom_addr,
    input  logic [4:0]       rom_data,
    input  logic             mag_valid,
    output logic             mag_ready,
    input  logic [MAG_W-1:0] mag_data,
    output logic             hist_valid,
    input  logic             hist_ready,
    output logic [4:0]       hist_bin,
    output logic [ACC_W-1:0] hist_data,
    output logic             hist_last
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] addr_reg, addr_next;
    logic [4:0] beat_reg, beat_next;
    logic       done_reg, done_next;
    logic       mag_fire;
    logic       clear_bins;

    logic [ACC_W-1:0] bin_val [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            beat_reg  <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            beat_reg  <= beat_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        beat_next  = beat_reg;
        done_next  = 1'b0;
        clear_bins = 1'b0;
        mag_fire   = 1'b0;
        busy       = 1'b1;
        mag_ready  = 1'b0;
        hist_valid = 1'b0;
        hist_last  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                clear_bins = 1'b1;
                addr_next  = '0;
                beat_next  = '0;
                state_next = ST_ACCUM;
            end
            ST_ACCUM: begin
                mag_ready = 1'b1;
                // The ROM is combinational on addr_reg, so the bin and magnitude pair up in-cycle.
                if (mag_valid) begin
                    mag_fire  = 1'b1;
                    addr_next = addr_reg + 8'd1;
                    if (addr_reg == 8'hFF) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                hist_valid = 1'b1;
                hist_last  = (beat_reg == 5'd31);
                if (hist_ready) begin
                    beat_next = beat_reg + 5'd1;
                    if (beat_reg == 5'd31) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_bin
            logic [ACC_W-1:0] bin_reg;
            logic [ACC_W-1:0] bin_next;
            logic             hit;

            assign hit = mag_fire && (rom_data == 5'(gi));

`ifdef DIR_HIST_SAT_EN
            logic [ACC_W:0] sum_full;
            assign sum_full = {1'b0, bin_reg} + (ACC_W+1)'(mag_data);
            assign bin_next = sum_full[ACC_W] ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
            assign bin_next = bin_reg + ACC_W'(mag_data);
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    bin_reg <= '0;
                end else if (clear_bins) begin
                    bin_reg <= '0;
                end else if (hit) begin
                    bin_reg <= bin_next;
                end
            end

            assign bin_val[gi] = bin_reg;
        end
    endgenerate

    assign done      = done_reg;
    assign rom_addr  = addr_reg;
    assign hist_bin  = beat_reg;
    assign hist_data = bin_val[beat_reg];

endmodule

// File: tb/tb_dir_hist_sched.sv
// Bench for dir_hist_sched: table of window scenarios checked through an expected-beat queue,
// plus hand-written reset and idle sequences.
module tb_dir_hist_sched;
    localparam int MAG_W = 8;
    localparam int ACC_W = 12;
    localparam int ACC_MAX = (1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             busy, done;
    logic [7:0]       rom_addr;
    logic [4:0]       rom_data;
    logic             mag_valid = 1'b0;
    logic             mag_ready;
    logic [MAG_W-1:0] mag_data = '0;
    logic             hist_valid;
    logic             hist_ready = 1'b0;
    logic [4:0]       hist_bin;
    logic [ACC_W-1:0] hist_data;
    logic             hist_last;

    int rom_mode = 0;
    int fixed_bin = 0;
    int unsigned cyc = 0;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4:0] rom_func(input int mode, input int fb, input int a);
        if (mode == 0) return 5'(fb);
        return 5'((a * 37 + (a >> 4) * 11 + 3) % 32);
    endfunction

    always_comb rom_data = rom_func(rom_mode, fixed_bin, int'(rom_addr));

    dir_hist_sched #(.MAG_W(MAG_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .mag_valid(mag_valid), .mag_ready(mag_ready), .mag_data(mag_data),
        .hist_valid(hist_valid), .hist_ready(hist_ready), .hist_bin(hist_bin),
        .hist_data(hist_data), .hist_last(hist_last)
    );

    typedef struct {
        logic [4:0]       bin;
        logic [ACC_W-1:0] data;
        logic             last;
    } beat_t;
    beat_t exp_q[$];

    typedef struct {
        int rom_mode;
        int fixed_bin;
        int mag_mode;   // 0 constant, 1 random
        int mag_const;
        bit gaps;
        bit stalls;
        int exp_sum;    // -1: no fixed total
        int chk_bin;    // -1: no single-bin check
        int exp_chk;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end else begin
            $display("[TB] ok %s = %0d", name, act);
        end
    endtask

    task automatic run_window(input vec_t v, input string tag);
        int model[32];
        int k, b, m, nb, dcnt, budget, addr_err, hold_err, stalls_seen, sum, act_chk;
        int unsigned t0, t1;
        bit vnow, pstall, got_done;
        logic [4:0] pb;
        logic [ACC_W-1:0] pd;
        logic pl;
        beat_t e;

        for (int i = 0; i < 32; i++) model[i] = 0;
        rom_mode = v.rom_mode;
        fixed_bin = v.fixed_bin;
        k = 0; nb = 0; dcnt = 0; addr_err = 0; hold_err = 0; stalls_seen = 0;
        sum = 0; act_chk = -1; pstall = 1'b0; got_done = 1'b0; t1 = 0;
        pb = '0; pd = '0; pl = 1'b0;

        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);

        budget = 0;
        while (k < 256 && budget < 4000) begin
            if (done) dcnt++;
            vnow = v.gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            m = (v.mag_mode == 0) ? v.mag_const : int'($urandom_range(0, 255));
            mag_valid = vnow;
            mag_data = MAG_W'(m);
            if (v.gaps) start = ($urandom_range(0, 7) == 0);
            if (vnow && mag_ready) begin
                if (rom_addr !== 8'(k)) addr_err++;
                b = int'(rom_func(v.rom_mode, v.fixed_bin, k));
`ifdef DIR_HIST_SAT_EN
                model[b] = (model[b] + m > ACC_MAX) ? ACC_MAX : model[b] + m;
`else
                model[b] = (model[b] + m) % (ACC_MAX + 1);
`endif
                k++;
            end
            budget++;
            @(negedge clk);
        end
        mag_valid = 1'b0;
        start = 1'b0;
        check({tag, "_samples_accepted"}, 32'(k), 32'd256);

        for (int i = 0; i < 32; i++) begin
            e.bin = 5'(i);
            e.data = ACC_W'(model[i]);
            e.last = (i == 31);
            exp_q.push_back(e);
        end

        budget = 0;
        while (nb < 32 && budget < 4000) begin
            if (done) dcnt++;
            if (pstall) begin
                stalls_seen++;
                if (hist_valid !== 1'b1 || hist_bin !== pb || hist_data !== pd || hist_last !== pl)
                    hold_err++;
            end
            hist_ready = v.stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (v.stalls) start = ($urandom_range(0, 7) == 0);
            if (hist_valid && hist_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (hist_bin !== e.bin || hist_data !== e.data || hist_last !== e.last) begin
                    fails++;
                    $display("FAIL %s_beat%0d: got bin=%0d data=%0d last=%0d, expected bin=%0d data=%0d last=%0d",
                             tag, nb, hist_bin, hist_data, hist_last, e.bin, e.data, e.last);
                end
                sum += int'(hist_data);
                if (int'(hist_bin) == v.chk_bin) act_chk = int'(hist_data);
                nb++;
                pstall = 1'b0;
            end else begin
                pstall = hist_valid;
                pb = hist_bin;
                pd = hist_data;
                pl = hist_last;
            end
            budget++;
            @(negedge clk);
        end
        hist_ready = 1'b0;
        start = 1'b0;
        check({tag, "_beats_drained"}, 32'(nb), 32'd32);
        exp_q.delete();

        for (int i = 0; i < 4; i++) begin
            if (done) begin
                dcnt++;
                if (!got_done) t1 = cyc;
                got_done = 1'b1;
            end
            @(negedge clk);
        end
        check({tag, "_done_pulses"}, 32'(dcnt), 32'd1);
        if (!v.gaps && !v.stalls)
            check({tag, "_start_to_done_edges"}, 32'(t1 - t0), 32'(1 + 256 + 32 + 1));
        check({tag, "_idle_after_done"}, {30'd0, busy, hist_valid}, 32'd0);
        check({tag, "_rom_addr_seq_errors"}, 32'(addr_err), 32'd0);
        if (stalls_seen > 0) check({tag, "_stall_hold_errors"}, 32'(hold_err), 32'd0);
        if (v.exp_sum >= 0) check({tag, "_bin_sum"}, 32'(sum), 32'(v.exp_sum));
        if (v.chk_bin >= 0) check({tag, "_chk_bin"}, 32'(act_chk), 32'(v.exp_chk));
    endtask

    initial begin
        int k, bad;
        int sat_val;
`ifdef DIR_HIST_SAT_EN
        sat_val = 4095;
`else
        sat_val = 3840;
`endif
        vecs[0] = '{0, 5,  0, 1,   1'b0, 1'b0, 256, 5,  256};
        vecs[1] = '{1, 0,  0, 3,   1'b0, 1'b0, 768, -1, 0};
        vecs[2] = '{0, 7,  0, 255, 1'b0, 1'b0, sat_val, 7, sat_val};
        vecs[3] = '{1, 0,  1, 0,   1'b1, 1'b1, -1,  -1, 0};
        vecs[4] = '{0, 31, 0, 2,   1'b1, 1'b0, 512, 31, 512};
        vecs[5] = '{1, 0,  0, 3,   1'b0, 1'b1, 768, -1, 0};

        #1;
        check("reset_outputs", {21'd0, busy, done, mag_ready, hist_valid, hist_last, hist_bin, rom_addr}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Magnitudes offered while idle must not move the sample counter.
        mag_valid = 1'b1;
        mag_data = 8'd9;
        repeat (3) @(negedge clk);
        check("idle_ignores_mag", {23'd0, mag_ready, rom_addr}, 32'd0);
        mag_valid = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_window(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of accumulation, then a clean window.
        rom_mode = 0;
        fixed_bin = 5;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        for (int c = 0; c < 400 && k < 100; c++) begin
            mag_valid = 1'b1;
            mag_data = 8'd4;
            if (mag_ready) k++;
            @(negedge clk);
        end
        mag_valid = 1'b0;
        check("midaccum_rom_addr", 32'(rom_addr), 32'd100);
        rst_n = 1'b0;
        #1;
        check("midaccum_reset_outputs", {21'd0, busy, done, mag_ready, hist_valid, hist_last, hist_bin, rom_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            if (hist_valid || busy || done) bad++;
            @(negedge clk);
        end
        check("no_output_after_reset", 32'(bad), 32'd0);
        run_window(vecs[0], "post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
